// File: rtl/game_timer_ctrl.sv
// Game timer: count-down/count-up with start/pause, bonus adds, warning, done and BCD digits.
// Optional macro TIMER_BCD_EN builds the binary-to-BCD digit outputs; otherwise digits are 0.
module game_timer_ctrl #(
    parameter int unsigned TIMER_BITS = 7,
    parameter int unsigned MAX_TIME   = 30,
    parameter int unsigned WARN_TIME  = 5,
    parameter int unsigned ADD_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  load,
    input  logic                  use_default,
    input  logic [TIMER_BITS-1:0] load_value,
    input  logic                  mode,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  add_en,
    input  logic [ADD_BITS-1:0]   add_value,
    output logic [TIMER_BITS-1:0] current_time,
    output logic                  running,
    output logic                  warning,
    output logic                  timer_done,
    output logic                  done_pulse,
    output logic [3:0]            bcd_tens,
    output logic [3:0]            bcd_ones
);

    localparam int unsigned SumW = TIMER_BITS + 2;
    localparam logic [TIMER_BITS-1:0] MaxVal   = TIMER_BITS'(MAX_TIME);
    localparam logic [TIMER_BITS-1:0] WarnVal  = TIMER_BITS'(WARN_TIME);
    localparam logic [TIMER_BITS-1:0] CountMax = '1;

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [TIMER_BITS-1:0] count_q, count_d;
    logic [TIMER_BITS-1:0] target_q, target_d;
    logic                  warning_q, warning_d;
    logic                  done_pulse_q, done_pulse_d;

    logic [TIMER_BITS-1:0] load_val;
    logic [TIMER_BITS-1:0] remaining_d;
    logic                  terminal;
    logic                  tick_run;
    logic [SumW-1:0]       add_amt;
    logic [SumW-1:0]       sum;

    always_comb begin
        load_val = use_default ? MaxVal : load_value;
        terminal = mode_q ? (count_q == target_q) : (count_q == '0);
        tick_run = tick && (state_q == StRun);
        add_amt  = (add_en && !mode_q) ? SumW'(add_value) : '0;
        sum      = SumW'(count_q) + add_amt - SumW'(tick_run);
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        count_d      = count_q;
        target_d     = target_q;
        done_pulse_d = 1'b0;

        if (load) begin
            mode_d  = mode;
            state_d = StIdle;
            if (mode) begin
                count_d  = '0;
                target_d = load_val;
            end else begin
                count_d = load_val;
            end
        end else if (pause && state_q == StRun) begin
            state_d = StPaused;
        end else if (start && (state_q == StIdle || state_q == StPaused)) begin
            if (terminal) begin
                state_d      = StDone;
                done_pulse_d = 1'b1;
            end else begin
                state_d = StRun;
            end
        end else if (state_q == StRun || state_q == StPaused) begin
            if (!mode_q) begin
                // Down mode: tick and bonus add combine, saturating at the register maximum
                count_d = (sum > SumW'(CountMax)) ? CountMax : sum[TIMER_BITS-1:0];
                if (sum == '0) begin
                    state_d      = StDone;
                    done_pulse_d = 1'b1;
                end
            end else if (tick_run) begin
                count_d = count_q + TIMER_BITS'(1);
                if (count_d == target_q) begin
                    state_d      = StDone;
                    done_pulse_d = 1'b1;
                end
            end
        end

        remaining_d = mode_d ? (target_d - count_d) : count_d;
        warning_d   = (state_d == StRun || state_d == StPaused) &&
                      (remaining_d != '0) && (remaining_d <= WarnVal);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            count_q      <= MaxVal;
            target_q     <= MaxVal;
            warning_q    <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            target_q     <= target_d;
            warning_q    <= warning_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign current_time = count_q;
    assign running      = (state_q == StRun);
    assign timer_done   = (state_q == StDone);
    assign warning      = warning_q;
    assign done_pulse   = done_pulse_q;

`ifdef TIMER_BCD_EN
    int unsigned bin_val;

    always_comb begin
        bin_val = 32'(count_q);
        if (bin_val > 32'd99) begin
            bcd_tens = 4'd9;
            bcd_ones = 4'd9;
        end else begin
            bcd_tens = 4'(bin_val / 32'd10);
            bcd_ones = 4'(bin_val % 32'd10);
        end
    end
`else
    assign bcd_tens = 4'd0;
    assign bcd_ones = 4'd0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed scenarios plus random stimulus against
// an arithmetic reference model of the timer rules.
module tb_game_timer_ctrl;

    localparam int TB_BITS  = 7;
    localparam int TB_MAX   = 30;
    localparam int TB_WARN  = 5;
    localparam int TB_CMAX  = (1 << TB_BITS) - 1;

    // Model phases (bench-local numbering)
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_PAUSE = 2;
    localparam int P_DONE  = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             tick = 1'b0;
    logic             load = 1'b0;
    logic             use_default = 1'b0;
    logic [6:0]       load_value = '0;
    logic             mode = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             add_en = 1'b0;
    logic [3:0]       add_value = '0;
    logic [6:0]       current_time;
    logic             running;
    logic             warning;
    logic             timer_done;
    logic             done_pulse;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;

    int total = 0;
    int bad = 0;

    int m_phase, m_mode, m_count, m_target, m_warn, m_pulse;

    game_timer_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .load         (load),
        .use_default  (use_default),
        .load_value   (load_value),
        .mode         (mode),
        .start        (start),
        .pause        (pause),
        .add_en       (add_en),
        .add_value    (add_value),
        .current_time (current_time),
        .running      (running),
        .warning      (warning),
        .timer_done   (timer_done),
        .done_pulse   (done_pulse),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_mode = 0; m_count = TB_MAX; m_target = TB_MAX;
        m_warn = 0; m_pulse = 0;
    endtask

    // Apply one clock of the timer rules to the model using the currently driven inputs
    task automatic model_step();
        int v, rem, t, a, r;
        m_pulse = 0;
        if (load) begin
            v = use_default ? TB_MAX : int'(load_value);
            m_mode = int'(mode);
            if (m_mode == 0) m_count = v;
            else begin m_count = 0; m_target = v; end
            m_phase = P_IDLE;
        end else if (pause && m_phase == P_RUN) begin
            m_phase = P_PAUSE;
        end else if (start && (m_phase == P_IDLE || m_phase == P_PAUSE)) begin
            if ((m_mode == 0 && m_count == 0) || (m_mode == 1 && m_count == m_target)) begin
                m_phase = P_DONE; m_pulse = 1;
            end else m_phase = P_RUN;
        end else if (m_phase == P_RUN || m_phase == P_PAUSE) begin
            t = (tick && m_phase == P_RUN) ? 1 : 0;
            if (m_mode == 0) begin
                a = add_en ? int'(add_value) : 0;
                r = m_count - t + a;
                m_count = (r > TB_CMAX) ? TB_CMAX : r;
                if (m_count == 0) begin m_phase = P_DONE; m_pulse = 1; end
            end else if (t == 1) begin
                m_count = m_count + 1;
                if (m_count == m_target) begin m_phase = P_DONE; m_pulse = 1; end
            end
        end
        rem = (m_mode == 1) ? m_target - m_count : m_count;
        m_warn = ((m_phase == P_RUN || m_phase == P_PAUSE) && rem >= 1 && rem <= TB_WARN)
                 ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        int et, eo;
        chk({tag, ".time"}, 32'(current_time), 32'(m_count));
        chk({tag, ".run"}, 32'(running), 32'(m_phase == P_RUN));
        chk({tag, ".warn"}, 32'(warning), 32'(m_warn));
        chk({tag, ".done"}, 32'(timer_done), 32'(m_phase == P_DONE));
        chk({tag, ".pulse"}, 32'(done_pulse), 32'(m_pulse));
`ifdef TIMER_BCD_EN
        if (m_count > 99) begin et = 9; eo = 9; end
        else begin et = m_count / 10; eo = m_count % 10; end
`else
        et = 0; eo = 0;
`endif
        chk({tag, ".tens"}, 32'(bcd_tens), 32'(et));
        chk({tag, ".ones"}, 32'(bcd_ones), 32'(eo));
    endtask

    task automatic clear_inputs();
        tick = 0; load = 0; use_default = 0; load_value = '0; mode = 0;
        start = 0; pause = 0; add_en = 0; add_value = '0;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        clear_inputs();
    endtask

    task automatic do_idle(input string tag);
        step(tag);
    endtask

    task automatic do_tick(input string tag);
        tick = 1; step(tag);
    endtask

    task automatic do_start(input string tag);
        start = 1; step(tag);
    endtask

    task automatic do_pause(input string tag);
        pause = 1; step(tag);
    endtask

    task automatic do_load(input string tag, input logic ud, input int lv, input logic md);
        load = 1; use_default = ud; load_value = 7'(lv); mode = md; step(tag);
    endtask

    task automatic do_add(input string tag, input int av, input logic tk);
        add_en = 1; add_value = 4'(av); tick = tk; step(tag);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset_n = 0;
        #12;
        check_all("reset");
        reset_n = 1;
        @(negedge clk);

        // Full default countdown with idle gaps between ticks
        do_load("ld_def", 1, 0, 0);
        do_start("start30");
        for (int i = 0; i < 30; i++) begin
            do_tick("down30");
            do_idle("gap30");
        end
        do_idle("done_hold");
        do_tick("done_tick");
        do_add("done_add", 5, 0);
        do_start("done_start");

        // Bonus add with simultaneous tick, then saturation
        do_load("ld_def2", 1, 0, 0);
        do_start("start2");
        for (int i = 0; i < 27; i++) do_tick("to3");
        do_add("add10tick", 10, 1);
        do_load("ld125", 0, 125, 0);
        do_start("start125");
        do_add("add15sat", 15, 0);
        do_add("add_zero", 0, 0);

        // Pause holds the count; start resumes
        do_load("ld_def3", 1, 0, 0);
        do_start("start3");
        for (int i = 0; i < 10; i++) do_tick("to20");
        do_pause("pause20");
        for (int i = 0; i < 5; i++) do_tick("paused_tick");
        do_add("paused_add", 2, 1);
        do_start("resume");
        do_tick("after_resume");

        // Count-up to 4, adds ignored
        do_load("ld_up4", 0, 4, 1);
        do_start("start_up");
        do_add("up_add", 9, 0);
        for (int i = 0; i < 4; i++) do_tick("up");
        do_idle("up_done");

        // Zero load finishes immediately on start
        do_load("ld_zero", 0, 0, 0);
        do_start("start_zero");
        do_idle("zero_hold");

        // Load aborts a run
        do_load("ld_def4", 1, 0, 0);
        do_start("start4");
        do_tick("t4");
        do_load("ld_abort", 0, 47, 0);
        do_load("ld_120", 0, 120, 0);

        // Asynchronous reset in mid-run
        do_load("ld_def5", 1, 0, 0);
        do_start("start5");
        for (int i = 0; i < 26; i++) do_tick("to4");
        #3;
        reset_n = 0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        check_all("post_rst");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            load        = ($urandom_range(0, 99) < 3);
            use_default = ($urandom_range(0, 3) == 0);
            load_value  = 7'($urandom_range(0, 127));
            mode        = $urandom_range(0, 1) == 1;
            start       = ($urandom_range(0, 99) < 12);
            pause       = ($urandom_range(0, 99) < 6);
            tick        = ($urandom_range(0, 99) < 40);
            add_en      = ($urandom_range(0, 99) < 10);
            add_value   = 4'($urandom_range(0, 15));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
